// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings and defaults for the multiply/divide unit
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational signed/unsigned multiply and divide
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o,
  output logic        div0_o
);

  logic        is_signed;
  logic        is_div;
  logic [63:0] prod;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] uq;
  logic [31:0] ur;

  // Signed divide works on magnitudes so the most-negative/-1 case cannot overflow.
  always_comb begin
    is_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
    is_div    = (op_i == MD_DIV) || (op_i == MD_DIVU);
    div0_o    = is_div && (rt_i == 32'd0);

    if (is_signed)
      prod = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
    else
      prod = {32'd0, rs_i} * {32'd0, rt_i};

    rs_mag = (is_signed && rs_i[31]) ? (32'd0 - rs_i) : rs_i;
    rt_mag = (is_signed && rt_i[31]) ? (32'd0 - rt_i) : rt_i;
    if (rt_mag == 32'd0)
      rt_mag = 32'd1;
    uq = rs_mag / rt_mag;
    ur = rs_mag % rt_mag;

    if (is_div) begin
      res_lo_o = (is_signed && (rs_i[31] ^ rt_i[31])) ? (32'd0 - uq) : uq;
      res_hi_o = (is_signed && rs_i[31]) ? (32'd0 - ur) : ur;
    end else begin
      res_hi_o = prod[63:32];
      res_lo_o = prod[31:0];
    end
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - HI/LO owner and multi-cycle mult/div sequencer for the E stage
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  E_MDOp,
  input  logic        E_Start,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
  input  logic        D_IsMD,
  output logic        Busy,
  output logic        MD_Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] tmp_hi_q, tmp_hi_d;
  logic [31:0] tmp_lo_q, tmp_lo_d;
  logic        commit_q, commit_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div0;
  logic        start;
  logic        is_div_op;
  logic        last;

  md_arith u_arith (
    .op_i     (E_MDOp),
    .rs_i     (E_RS),
    .rt_i     (E_RT),
    .res_hi_o (res_hi),
    .res_lo_o (res_lo),
    .div0_o   (div0)
  );

  assign start     = E_Start && (E_MDOp >= MD_MULT) && (E_MDOp <= MD_DIVU);
  assign is_div_op = (E_MDOp == MD_DIV) || (E_MDOp == MD_DIVU);
  assign last      = (cnt_q <= CW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Busy     = (state_q == S_RUN);
    MD_Stall = D_IsMD && (Busy || E_Start);
    HI       = hi_q;
    LO       = lo_q;
  end

  // Result is captured at the start edge; HI/LO only change at the final edge.
  always_comb begin
    cnt_d    = cnt_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    commit_d = commit_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        tmp_hi_d = res_hi;
        tmp_lo_d = res_lo;
        commit_d = !div0;
        cnt_d    = is_div_op ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (E_MDOp == MD_MTHI) begin
        hi_d = E_RS;
      end else if (E_MDOp == MD_MTLO) begin
        lo_d = E_RS;
      end
    end else if (last) begin
      cnt_d = '0;
      if (commit_q) begin
        hi_d = tmp_hi_q;
        lo_d = tmp_lo_q;
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      commit_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      commit_q <= commit_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule
